// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Grants one operation at a time: accept, execute, hold response.
module alu_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic [2:0]  i_req0_op,
  input  logic        i_req0_sub,
  input  logic        i_req0_arith_shift,
  input  logic [2:0]  i_req0_branch_op,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  input  logic [2:0]  i_req1_op,
  input  logic        i_req1_sub,
  input  logic        i_req1_arith_shift,
  input  logic [2:0]  i_req1_branch_op,
  output logic        o_rsp0_valid,
  output logic [31:0] o_rsp0_y,
  output logic        o_rsp0_will_branch,
  input  logic        i_rsp0_ready,
  output logic        o_rsp1_valid,
  output logic [31:0] o_rsp1_y,
  output logic        o_rsp1_will_branch,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [2:0]  o_alu_op,
  output logic        o_alu_sub,
  output logic        o_alu_arith_shift,
  output logic [2:0]  o_alu_branch_op,
  input  logic [31:0] i_alu_y,
  input  logic        i_alu_will_branch,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        owner_q;
  logic        last_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic        sub_q;
  logic        sh_q;
  logic [2:0]  bop_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;
  logic [31:0] rsp0_y_q;
  logic [31:0] rsp1_y_q;
  logic        rsp0_wb_q;
  logic        rsp1_wb_q;

  logic idle;
  logic pick1;
  logic gnt0;
  logic gnt1;
  logic owner_rdy;

  assign idle  = (state_q == IDLE) & ~i_rst;
  // Requester 1 wins a tie only in round-robin mode after 0 was served.
  assign pick1 = i_req1_valid &
                 (~i_req0_valid | (~FIXED_PRIORITY & ~last_q));
  assign gnt1  = idle & pick1;
  assign gnt0  = idle & i_req0_valid & ~pick1;
  assign owner_rdy = owner_q ? i_rsp1_ready : i_rsp0_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      sub_q        <= 1'b0;
      sh_q         <= 1'b0;
      bop_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_y_q     <= '0;
      rsp1_y_q     <= '0;
      rsp0_wb_q    <= 1'b0;
      rsp1_wb_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt0 | gnt1) begin
            owner_q <= gnt1;
            last_q  <= gnt1;
            a_q     <= gnt1 ? i_req1_a : i_req0_a;
            b_q     <= gnt1 ? i_req1_b : i_req0_b;
            op_q    <= gnt1 ? i_req1_op : i_req0_op;
            sub_q   <= gnt1 ? i_req1_sub : i_req0_sub;
            sh_q    <= gnt1 ? i_req1_arith_shift
                            : i_req0_arith_shift;
            bop_q   <= gnt1 ? i_req1_branch_op
                            : i_req0_branch_op;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (owner_q) begin
            rsp1_valid_q <= 1'b1;
            rsp1_y_q     <= i_alu_y;
            rsp1_wb_q    <= i_alu_will_branch;
          end else begin
            rsp0_valid_q <= 1'b1;
            rsp0_y_q     <= i_alu_y;
            rsp0_wb_q    <= i_alu_will_branch;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (owner_rdy) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req0_ready       = gnt0;
  assign o_req1_ready       = gnt1;
  assign o_alu_a            = a_q;
  assign o_alu_b            = b_q;
  assign o_alu_op           = op_q;
  assign o_alu_sub          = sub_q;
  assign o_alu_arith_shift  = sh_q;
  assign o_alu_branch_op    = bop_q;
  assign o_rsp0_valid       = rsp0_valid_q;
  assign o_rsp0_y           = rsp0_y_q;
  assign o_rsp0_will_branch = rsp0_wb_q;
  assign o_rsp1_valid       = rsp1_valid_q;
  assign o_rsp1_y           = rsp1_y_q;
  assign o_rsp1_will_branch = rsp1_wb_q;
  assign o_busy             = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a
// transaction-level reference model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v[2];
  logic [31:0] a[2];
  logic [31:0] b[2];
  logic [2:0]  op[2];
  logic        sub[2];
  logic        sh[2];
  logic [2:0]  bop[2];
  logic        rr[2];

  logic        rdy0, rdy1, rv0, rv1, wb0, wb1, busy;
  logic [31:0] y0, y1;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_op, alu_bop;
  logic        alu_sub, alu_sh, alu_wb;

  // Reference ALU (RISC-V style op and branch codes), {will_branch, y}
  function automatic logic [32:0] alu(
    input logic [31:0] x, input logic [31:0] z,
    input logic [2:0] o, input logic s,
    input logic ar, input logic [2:0] bo);
    logic [31:0] r;
    logic        w;
    case (o)
      3'd0: r = s ? x - z : x + z;
      3'd1: r = x << z[4:0];
      3'd2: r = {31'd0, $signed(x) < $signed(z)};
      3'd3: r = {31'd0, x < z};
      3'd4: r = x ^ z;
      3'd5: r = ar ? $unsigned($signed(x) >>> z[4:0])
                   : x >> z[4:0];
      3'd6: r = x | z;
      default: r = x & z;
    endcase
    case (bo)
      3'd0: w = (x == z);
      3'd1: w = (x != z);
      3'd4: w = $signed(x) < $signed(z);
      3'd5: w = $signed(x) >= $signed(z);
      3'd6: w = x < z;
      3'd7: w = x >= z;
      default: w = 1'b0;
    endcase
    return {w, r};
  endfunction

  assign {alu_wb, alu_y} =
    alu(alu_a, alu_b, alu_op, alu_sub, alu_sh, alu_bop);

  alu_arbiter #(.FIXED_PRIORITY(1'b0)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v[0]), .o_req0_ready(rdy0),
    .i_req0_a(a[0]), .i_req0_b(b[0]), .i_req0_op(op[0]),
    .i_req0_sub(sub[0]), .i_req0_arith_shift(sh[0]),
    .i_req0_branch_op(bop[0]),
    .i_req1_valid(v[1]), .o_req1_ready(rdy1),
    .i_req1_a(a[1]), .i_req1_b(b[1]), .i_req1_op(op[1]),
    .i_req1_sub(sub[1]), .i_req1_arith_shift(sh[1]),
    .i_req1_branch_op(bop[1]),
    .o_rsp0_valid(rv0), .o_rsp0_y(y0),
    .o_rsp0_will_branch(wb0), .i_rsp0_ready(rr[0]),
    .o_rsp1_valid(rv1), .o_rsp1_y(y1),
    .o_rsp1_will_branch(wb1), .i_rsp1_ready(rr[1]),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .o_alu_sub(alu_sub), .o_alu_arith_shift(alu_sh),
    .o_alu_branch_op(alu_bop),
    .i_alu_y(alu_y), .i_alu_will_branch(alu_wb),
    .o_busy(busy)
  );

  // Fixed-priority instance, both requesters always valid
  logic        f_rst;
  logic        f_rdy0, f_rdy1, f_rv0, f_rv1, f_wb0, f_wb1, f_busy;
  logic [31:0] f_y0, f_y1, f_aa, f_ab, f_ay;
  logic [2:0]  f_aop, f_abop;
  logic        f_asub, f_ash, f_awb;

  assign {f_awb, f_ay} =
    alu(f_aa, f_ab, f_aop, f_asub, f_ash, f_abop);

  alu_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (
    .i_clk(clk), .i_rst(f_rst),
    .i_req0_valid(1'b1), .o_req0_ready(f_rdy0),
    .i_req0_a(32'd7), .i_req0_b(32'd1), .i_req0_op(3'd0),
    .i_req0_sub(1'b0), .i_req0_arith_shift(1'b0),
    .i_req0_branch_op(3'd0),
    .i_req1_valid(1'b1), .o_req1_ready(f_rdy1),
    .i_req1_a(32'd9), .i_req1_b(32'd2), .i_req1_op(3'd0),
    .i_req1_sub(1'b0), .i_req1_arith_shift(1'b0),
    .i_req1_branch_op(3'd0),
    .o_rsp0_valid(f_rv0), .o_rsp0_y(f_y0),
    .o_rsp0_will_branch(f_wb0), .i_rsp0_ready(1'b1),
    .o_rsp1_valid(f_rv1), .o_rsp1_y(f_y1),
    .o_rsp1_will_branch(f_wb1), .i_rsp1_ready(1'b1),
    .o_alu_a(f_aa), .o_alu_b(f_ab), .o_alu_op(f_aop),
    .o_alu_sub(f_asub), .o_alu_arith_shift(f_ash),
    .o_alu_branch_op(f_abop),
    .i_alu_y(f_ay), .i_alu_will_branch(f_awb),
    .o_busy(f_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  // Reference model: one transaction in flight at most
  bit          inflight;
  int          age;
  bit          own;
  bit          lastg;
  logic [31:0] exp_y;
  logic        exp_wb;
  logic [31:0] m_y[2];
  logic        m_wb[2];
  bit          rec;
  int          gq[$];

  task automatic mdl_reset();
    inflight = 0;
    age      = 0;
    own      = 0;
    lastg    = 1;
    m_y[0]   = '0;
    m_y[1]   = '0;
    m_wb[0]  = 1'b0;
    m_wb[1]  = 1'b0;
  endtask

  // Called at a negedge with inputs set; returns at next negedge
  task automatic step();
    bit acc;
    bit w;
    #1;
    if (rst) mdl_reset();
    acc = 0;
    w   = 0;
    if (!inflight && !rst && (v[0] || v[1])) begin
      acc = 1;
      if (v[0] && v[1]) w = ~lastg;
      else w = v[1];
    end
    chk("ready0", rdy0, acc && !w);
    chk("ready1", rdy1, acc && w);
    chk("busy", busy, inflight);
    chk("rsp0_valid", rv0, inflight && age == 2 && !own);
    chk("rsp1_valid", rv1, inflight && age == 2 && own);
    chk("rsp0_y", y0, m_y[0]);
    chk("rsp1_y", y1, m_y[1]);
    chk("rsp0_wb", wb0, m_wb[0]);
    chk("rsp1_wb", wb1, m_wb[1]);
    if (rec && rdy0) gq.push_back(0);
    if (rec && rdy1) gq.push_back(1);
    @(posedge clk);
    if (!rst) begin
      if (acc) begin
        inflight = 1;
        age      = 1;
        own      = w;
        lastg    = w;
        {exp_wb, exp_y} =
          alu(a[w], b[w], op[w], sub[w], sh[w], bop[w]);
      end else if (inflight && age == 1) begin
        age       = 2;
        m_y[own]  = exp_y;
        m_wb[own] = exp_wb;
      end else if (inflight && rr[own]) begin
        inflight = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    for (int n = 0; n < 2; n++) begin
      v[n] = 0; a[n] = 0; b[n] = 0; op[n] = 0;
      sub[n] = 0; sh[n] = 0; bop[n] = 0; rr[n] = 1;
    end
  endtask

  task automatic drain();
    v[0] = 0;
    v[1] = 0;
    rr[0] = 1;
    rr[1] = 1;
    repeat (4) step();
  endtask

  initial begin
    rst   = 1;
    f_rst = 1;
    rec   = 0;
    quiet();
    mdl_reset();
    @(negedge clk);
    step();

    // Fixed priority: requester 0 wins every third cycle
    f_rst = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("fp_ready0", f_rdy0, (i % 3) == 0);
      chk("fp_ready1", f_rdy1, 1'b0);
      @(negedge clk);
    end

    // Round-robin alternation from reset
    rst = 0;
    rec = 1;
    v[0] = 1; v[1] = 1;
    a[0] = 10; b[0] = 1; a[1] = 20; b[1] = 2;
    repeat (12) step();
    rec = 0;
    chk("rr_count", gq.size(), 4);
    for (int i = 0; i < gq.size(); i++)
      chk("rr_seq", gq[i], i % 2);
    drain();

    // Subtract on requester 0
    quiet();
    v[0] = 1; a[0] = 5; b[0] = 3; sub[0] = 1;
    step();
    v[0] = 0;
    step();
    #1;
    chk("sub_valid", rv0, 1);
    chk("sub_y", y0, 2);
    step();
    chk("sub_idle", busy, 0);

    // Arithmetic shift with response backpressure
    quiet();
    v[1] = 1; a[1] = 32'h8000_0000; b[1] = 4;
    op[1] = 3'b101; sh[1] = 1; rr[1] = 0;
    step();
    v[1] = 0;
    v[0] = 1; a[0] = 1; b[0] = 1;
    repeat (11) step();
    #1;
    chk("sra_y", y1, 32'hF800_0000);
    chk("sra_hold", rv1, 1);
    rr[1] = 1;
    step();
    drain();

    // Branch compares
    foreach (bop[n]) bop[n] = 0;
    quiet();
    v[0] = 1; a[0] = 32'hFFFF_FFFF; b[0] = 1; bop[0] = 3'b100;
    step();
    v[0] = 0;
    step();
    #1;
    chk("blt_wb", wb0, 1);
    step();
    v[0] = 1; bop[0] = 3'b110;
    step();
    v[0] = 0;
    step();
    #1;
    chk("bltu_wb", wb0, 0);
    drain();

    // Reset while executing
    quiet();
    v[0] = 1; a[0] = 3; b[0] = 4;
    step();
    v[0] = 0;
    rst = 1;
    step();
    rst = 0;
    repeat (4) step();
    chk("abort_v0", rv0, 0);

    // Non-owner ready is ignored
    quiet();
    v[1] = 1; a[1] = 6; b[1] = 7; op[1] = 3'd6;
    rr[0] = 1; rr[1] = 0;
    step();
    v[1] = 0;
    repeat (4) step();
    #1;
    chk("nonown_v1", rv1, 1);
    chk("nonown_v0", rv0, 0);
    rr[1] = 1;
    step();
    drain();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        v[n]   = ($urandom_range(0, 9) < 6);
        a[n]   = $urandom;
        b[n]   = ($urandom_range(0, 3) == 0) ? a[n]
                                             : $urandom;
        op[n]  = 3'($urandom_range(0, 7));
        sub[n] = 1'($urandom_range(0, 1));
        sh[n]  = 1'($urandom_range(0, 1));
        bop[n] = 3'($urandom_range(0, 7));
        rr[n]  = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRIORITY, default 0; 0 = round-robin grant, 1 = requester 0 always wins a tie.
REQ-002 Port: i_clk  input  1  single clock, all state on rising edge.
REQ-003 Port: i_rst  input  1  reset, asynchronous, active-high.
REQ-004 Ports, n in {0,1}: i_reqN_valid  input  1  requester n holds a valid operation.
REQ-005 Ports: o_reqN_ready  output  1  operation accepted this cycle when high with i_reqN_valid.
REQ-006 Ports: i_reqN_a, i_reqN_b  input  32 each  operands.
REQ-007 Ports: i_reqN_op  input  3  ALU op; i_reqN_sub  input  1  add/sub select; i_reqN_arith_shift  input  1  SRA/SRL select; i_reqN_branch_op  input  3  branch compare code.
REQ-008 Ports: o_rspN_valid  output  1  result held for requester n; o_rspN_y  output  32  result; o_rspN_will_branch  output  1  compare result; i_rspN_ready  input  1  requester n consumes result.
REQ-009 Ports: o_alu_a, o_alu_b  output  32; o_alu_op  output  3; o_alu_sub  output  1; o_alu_arith_shift  output  1; o_alu_branch_op  output  3 -- drive the shared combinational ALU.
REQ-010 Ports: i_alu_y  input  32; i_alu_will_branch  input  1 -- shared ALU results.
REQ-011 Port: o_busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE, EXEC, RESP; a 1-bit owner register SHALL record the granted requester.
REQ-013 In IDLE, o_reqN_ready SHALL be high, combinationally, only for the arbitration winner, and only when i_reqN_valid is high; ready SHALL be low in EXEC and RESP.
REQ-014 Arbitration: only one valid -> that one wins; both valid -> with FIXED_PRIORITY=0, the requester not granted last wins; with FIXED_PRIORITY=1, requester 0 wins.
REQ-015 On an accept edge, the winner's a, b, op, sub, arith_shift, branch_op SHALL be latched into operand registers, owner set, last-grant pointer updated, state -> EXEC.
REQ-016 o_alu_* SHALL always be driven from the operand registers, never from requester inputs directly.
REQ-017 In EXEC, on the next edge, i_alu_y and i_alu_will_branch SHALL be captured into the owner's response registers, o_rspN_valid set for the owner only, state -> RESP.
REQ-018 Latency: request accepted at edge k -> o_rspN_valid high from edge k+2; maximum throughput one operation per 3 cycles.
REQ-019 In RESP, o_rspN_valid, o_rspN_y, o_rspN_will_branch SHALL hold stable until i_rspN_ready is high for the owner; that edge clears valid and returns to IDLE.
REQ-020 i_rspN_ready of the non-owner SHALL be ignored; responses SHALL never be dropped or duplicated.
REQ-021 A requester deasserting valid before ready SHALL not be granted; inputs are sampled only on the accept edge.
REQ-022 Response data for a requester SHALL retain its last value after valid drops.
REQ-023 The ALU is external and combinational; this block SHALL add no arithmetic of its own.

Reset
REQ-024 While i_rst is high: state IDLE, owner 0, last-grant pointer 1 (so requester 0 wins the first tie), operand registers 0, o_rsp0/1_valid 0, response data 0, o_busy 0, all o_reqN_ready 0.
REQ-025 Reset asserted mid-operation SHALL abort it; no response is produced for the aborted request after release.
REQ-026 The first arbitration SHALL occur in the first cycle after i_rst deasserts.

Verification
REQ-027 Req0 only: a=5, b=3, op=000, sub=1, rsp0_ready=1 -> ready0 at accept cycle, o_rsp0_valid at k+2 with y=2, then IDLE.
REQ-028 Both valid continuously (rr): grants alternate 0,1,0,1; with FIXED_PRIORITY=1 all grants go to 0 while req0 stays valid.
REQ-029 Backpressure: req1 a=0x80000000, b=4, op=101, arith_shift=1, rsp1_ready low 10 cycles -> y=0xF8000000 held stable, no new grant until rsp1_ready high.
REQ-030 Branch: req0 a=0xFFFFFFFF, b=1, branch_op=100 -> will_branch=1; branch_op=110 -> will_branch=0.
REQ-031 Reset mid-EXEC: i_rst pulsed in EXEC -> valids 0, state IDLE, no stray response after release.
REQ-032 Non-owner ready: rsp0_ready high while owner is 1 -> o_rsp1_valid unaffected, o_rsp0_valid stays 0.
